// File: rtl/pc_seq_pkg.sv
// Shared types and default sizes for the program-counter sequencer.
package pc_seq_pkg;

  localparam int DEF_STACK_DEPTH = 4;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_OFF_W       = 9;

  // Decoder command encoding; 6 and 7 are illegal and fall to the default arm.
  typedef enum logic [2:0] {
    CMD_NEXT   = 3'd0,
    CMD_JUMP   = 3'd1,
    CMD_BRANCH = 3'd2,
    CMD_CALL   = 3'd3,
    CMD_RET    = 3'd4,
    CMD_HALT   = 3'd5
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_HALTED
  } state_t;

endpackage

// File: rtl/return_stack.sv
// Return-address LIFO. Top-of-stack is presented combinationally so a pop
// can use its data in the same cycle it is requested.
module return_stack
  import pc_seq_pkg::*;
#(
  parameter  int DEPTH = DEF_STACK_DEPTH,
  parameter  int W     = DEF_ADDR_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_wr_idx  = r_count[AW-1:0];
  assign w_rd_idx  = w_wr_idx - AW'(1);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[w_rd_idx];
  // A simultaneous push and pop is treated as a no-op on the stack.
  assign w_do_push = i_push && !i_pop && !o_full;
  assign w_do_pop  = i_pop && !i_push && !o_empty;

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[w_wr_idx] <= i_din;
  end

  // Occupancy counter, guarded against over/underflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          r_count <= '0;
    else if (w_do_push) r_count <= r_count + CW'(1);
    else if (w_do_pop)  r_count <= r_count - CW'(1);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode control FSM driving an external ProgramCounter. The PC free-runs
// (+1) unless told otherwise, so every non-advancing state reloads its own value.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter  int STACK_DEPTH = DEF_STACK_DEPTH,
  parameter  int ADDR_W      = DEF_ADDR_W,
  parameter  int OFF_W       = DEF_OFF_W,
  localparam int CNT_W       = $clog2(STACK_DEPTH) + 1
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic signed [ADDR_W-1:0] i_counter_value,
  output logic signed [ADDR_W-1:0] o_load_value,
  output logic                     o_load_enable,
  output logic signed [OFF_W-1:0]  o_offset,
  output logic                     o_offset_enable,
  output logic                     o_fetch_req,
  output logic [ADDR_W-1:0]        o_fetch_addr,
  input  logic                     i_fetch_ack,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_valid,
  input  logic [2:0]               i_cmd_type,
  input  logic [ADDR_W-1:0]        i_cmd_target,
  input  logic signed [OFF_W-1:0]  i_cmd_offset,
  input  logic                     i_cond_true,
  output logic                     o_halted,
  output logic                     o_stack_error,
  output logic [CNT_W-1:0]         o_stack_count
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_stack_err;
  logic              w_set_err;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [ADDR_W-1:0] w_push_data;
  logic [ADDR_W-1:0] w_pop_data;
  cmd_t              w_cmd;

  // Return address for CALL, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] f_wrap_inc(input logic signed [ADDR_W-1:0] v);
    return v + ADDR_W'(1);
  endfunction

  assign w_cmd         = cmd_t'(i_cmd_type);
  assign w_push_data   = f_wrap_inc(i_counter_value);
  assign o_fetch_addr  = i_counter_value;
  assign o_halted      = (r_state == ST_HALTED);
  assign o_stack_error = r_stack_err;

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .i_clk   (i_clock),
    .i_rst   (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_push_data),
    .o_dout  (w_pop_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_stack_count)
  );

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Sticky error flag; only reset clears it.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)        r_stack_err <= 1'b0;
    else if (w_set_err) r_stack_err <= 1'b1;
  end

  // Next state and PC/handshake drive; default is "hold the PC".
  always_comb begin
    w_state_nxt     = r_state;
    o_load_enable   = 1'b1;
    o_load_value    = i_counter_value;
    o_offset        = '0;
    o_offset_enable = 1'b0;
    o_fetch_req     = 1'b0;
    o_cmd_ready     = 1'b0;
    w_push          = 1'b0;
    w_pop           = 1'b0;
    w_set_err       = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALTED: begin
        if (i_start) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        o_fetch_req = 1'b1;
        if (i_fetch_ack) w_state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          w_state_nxt = ST_FETCH;
          case (w_cmd)
            CMD_NEXT: o_load_enable = 1'b0;
            CMD_JUMP: o_load_value = i_cmd_target;
            CMD_BRANCH: begin
              o_load_enable = 1'b0;
              if (i_cond_true) begin
                o_offset_enable = 1'b1;
                o_offset        = i_cmd_offset;
              end
            end
            CMD_CALL: begin
              if (w_full) begin
                w_set_err   = 1'b1;
                w_state_nxt = ST_HALTED;
              end else begin
                w_push       = 1'b1;
                o_load_value = i_cmd_target;
              end
            end
            CMD_RET: begin
              if (w_empty) begin
                w_set_err   = 1'b1;
                w_state_nxt = ST_HALTED;
              end else begin
                w_pop        = 1'b1;
                o_load_value = w_pop_data;
              end
            end
            CMD_HALT: w_state_nxt = ST_HALTED;
            default: begin
              w_set_err   = 1'b1;
              w_state_nxt = ST_HALTED;
            end
          endcase
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a ProgramCounter stand-in, a transaction-level model
// of the command semantics, a directed vector table, corner-case sequences and
// a randomized command stream.
module tb_pc_sequencer;

  localparam int AW    = 16;
  localparam int OW    = 9;
  localparam int DEPTH = 4;

  localparam logic [2:0] C_NEXT = 3'd0, C_JUMP = 3'd1, C_BRANCH = 3'd2,
                         C_CALL = 3'd3, C_RET = 3'd4, C_HALT = 3'd5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          fetch_ack = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_type = '0;
  logic [AW-1:0] cmd_target = '0;
  logic [OW-1:0] cmd_offset = '0;
  logic          cond = 1'b0;
  logic [AW-1:0] pc;

  logic [AW-1:0] load_value;
  logic          load_en;
  logic [OW-1:0] offset;
  logic          offset_en;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          cmd_ready;
  logic          halted;
  logic          stack_err;
  logic [2:0]    stack_count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_stack [$];
  bit            m_err;
  bit            m_halt;

  typedef struct {
    logic [2:0]    cmd;
    logic [AW-1:0] tgt;
    logic [OW-1:0] off;
    bit            cond;
    int            ack_dly;
    logic [AW-1:0] exp_pc;
    int            exp_cnt;
    bit            exp_err;
    bit            exp_halt;
  } vec_t;

  vec_t vecs [18];

  always #5 clk = ~clk;

  // ProgramCounter stand-in: load beats offset, otherwise count up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            pc <= '0;
    else if (load_en)   pc <= load_value;
    else if (offset_en) pc <= pc + {{(AW-OW){offset[OW-1]}}, offset};
    else                pc <= pc + 16'd1;
  end

  pc_sequencer #(.STACK_DEPTH(DEPTH), .ADDR_W(AW), .OFF_W(OW)) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_start         (start),
    .i_counter_value (pc),
    .o_load_value    (load_value),
    .o_load_enable   (load_en),
    .o_offset        (offset),
    .o_offset_enable (offset_en),
    .o_fetch_req     (fetch_req),
    .o_fetch_addr    (fetch_addr),
    .i_fetch_ack     (fetch_ack),
    .o_cmd_ready     (cmd_ready),
    .i_cmd_valid     (cmd_valid),
    .i_cmd_type      (cmd_type),
    .i_cmd_target    (cmd_target),
    .i_cmd_offset    (cmd_offset),
    .i_cond_true     (cond),
    .o_halted        (halted),
    .o_stack_error   (stack_err),
    .o_stack_count   (stack_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Architectural effect of one accepted command.
  task automatic model_apply(input logic [2:0] c, input logic [AW-1:0] t,
                             input logic [OW-1:0] o, input bit cnd);
    logic [AW-1:0] ret;
    case (c)
      C_NEXT:   m_pc = m_pc + 16'd1;
      C_JUMP:   m_pc = t;
      C_BRANCH: m_pc = cnd ? m_pc + {{(AW-OW){o[OW-1]}}, o} : m_pc + 16'd1;
      C_CALL: begin
        if (m_stack.size() == DEPTH) begin
          m_err = 1; m_halt = 1;
        end else begin
          ret = m_pc + 16'd1;
          m_stack.push_back(ret);
          m_pc = t;
        end
      end
      C_RET: begin
        if (m_stack.size() == 0) begin
          m_err = 1; m_halt = 1;
        end else m_pc = m_stack.pop_back();
      end
      C_HALT:  m_halt = 1;
      default: begin m_err = 1; m_halt = 1; end
    endcase
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_count"}, stack_count, m_stack.size());
    chk({tag, "_err"}, stack_err, m_err);
    chk({tag, "_halted"}, halted, m_halt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    start = 0; fetch_ack = 0; cmd_valid = 0;
    m_pc = '0; m_stack.delete(); m_err = 0; m_halt = 0;
    #1;
    chk("rst_fetch_req", fetch_req, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_offset_en", offset_en, 0);
    chk("rst_hold_load", load_en, 1);
    chk("rst_pc", pc, 0);
    chk("rst_count", stack_count, 0);
    chk("rst_err", stack_err, 0);
    chk("rst_halted", halted, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_run();
    chk("pre_start_halted", halted, m_halt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_halt = 0;
    #1;
    chk("start_fetch_req", fetch_req, 1);
    chk("start_pc_held", pc, m_pc);
  endtask

  // One full fetch/decode round trip ending one edge after acceptance.
  task automatic exec_cmd(input logic [2:0] c, input logic [AW-1:0] t,
                          input logic [OW-1:0] o, input bit cnd,
                          input int ack_dly, input int dec_dly, input bit noise);
    int n = 0;
    while (fetch_req !== 1'b1 && n < 8) begin
      @(negedge clk); #1; n++;
    end
    chk("fetch_wait", fetch_req, 1);
    if (fetch_req !== 1'b1) return;
    chk("fetch_addr", fetch_addr, m_pc);
    for (int i = 0; i < ack_dly; i++) begin
      if (noise) begin
        start = 1'($urandom); cmd_valid = 1'($urandom);
        cmd_type = 3'($urandom); cmd_target = 16'($urandom);
      end
      @(negedge clk); #1;
      chk("fetch_hold_pc", pc, m_pc);
      chk("fetch_hold_req", fetch_req, 1);
      chk("fetch_hold_addr", fetch_addr, m_pc);
    end
    start = 0; cmd_valid = 0;
    fetch_ack = 1'b1;
    @(negedge clk);
    fetch_ack = 1'b0;
    for (int i = 0; i < dec_dly; i++) begin
      if (noise) begin
        fetch_ack = 1'($urandom); start = 1'($urandom);
      end
      #1;
      chk("decode_ready", cmd_ready, 1);
      @(negedge clk); #1;
      chk("decode_hold_pc", pc, m_pc);
    end
    fetch_ack = 0; start = 0;
    cmd_type = c; cmd_target = t; cmd_offset = o; cond = cnd;
    cmd_valid = 1'b1;
    #1;
    chk("accept_ready", cmd_ready, 1);
    model_apply(c, t, o, cnd);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    check_state("cmd");
    chk("next_fetch_req", fetch_req, !m_halt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //             cmd       tgt      off     cnd dly exp_pc  cnt err halt
    vecs[0]  = '{C_NEXT,   16'h0,    9'h0,   0, 0, 16'h0001, 0, 0, 0};
    vecs[1]  = '{C_NEXT,   16'h0,    9'h0,   0, 1, 16'h0002, 0, 0, 0};
    vecs[2]  = '{C_NEXT,   16'h0,    9'h0,   0, 0, 16'h0003, 0, 0, 0};
    vecs[3]  = '{C_NEXT,   16'h0,    9'h0,   0, 0, 16'h0004, 0, 0, 0};
    vecs[4]  = '{C_NEXT,   16'h0,    9'h0,   0, 0, 16'h0005, 0, 0, 0};
    vecs[5]  = '{C_JUMP,   16'h00F0, 9'h0,   0, 3, 16'h00F0, 0, 0, 0};
    vecs[6]  = '{C_JUMP,   16'h0040, 9'h0,   0, 0, 16'h0040, 0, 0, 0};
    vecs[7]  = '{C_BRANCH, 16'h0,    9'h1F0, 1, 0, 16'h0030, 0, 0, 0};
    vecs[8]  = '{C_JUMP,   16'h0040, 9'h0,   0, 0, 16'h0040, 0, 0, 0};
    vecs[9]  = '{C_BRANCH, 16'h0,    9'h1F0, 0, 0, 16'h0041, 0, 0, 0};
    vecs[10] = '{C_JUMP,   16'h0010, 9'h0,   0, 0, 16'h0010, 0, 0, 0};
    vecs[11] = '{C_CALL,   16'h0200, 9'h0,   0, 0, 16'h0200, 1, 0, 0};
    vecs[12] = '{C_RET,    16'h0,    9'h0,   0, 0, 16'h0011, 0, 0, 0};
    vecs[13] = '{C_BRANCH, 16'h0,    9'h005, 1, 0, 16'h0016, 0, 0, 0};
    vecs[14] = '{C_JUMP,   16'hFFFF, 9'h0,   0, 0, 16'hFFFF, 0, 0, 0};
    vecs[15] = '{C_NEXT,   16'h0,    9'h0,   0, 0, 16'h0000, 0, 0, 0};
    vecs[16] = '{C_BRANCH, 16'h0,    9'h1FF, 1, 0, 16'hFFFF, 0, 0, 0};
    vecs[17] = '{C_HALT,   16'h0,    9'h0,   0, 2, 16'hFFFF, 0, 0, 1};

    // Directed table
    do_reset();
    start_run();
    for (int i = 0; i < 18; i++) begin
      exec_cmd(vecs[i].cmd, vecs[i].tgt, vecs[i].off, vecs[i].cond, vecs[i].ack_dly, 0, 0);
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_count", i), stack_count, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_err", i), stack_err, vecs[i].exp_err);
      chk($sformatf("vec%0d_halted", i), halted, vecs[i].exp_halt);
    end
    repeat (2) @(negedge clk);
    #1;
    chk("halt_pc_held", pc, 16'hFFFF);
    start_run();
    exec_cmd(C_NEXT, 16'h0, 9'h0, 0, 0, 0, 0);
    chk("resume_pc", pc, 16'h0000);

    // Stack overflow, then resume with the stack intact
    do_reset();
    start_run();
    exec_cmd(C_CALL, 16'h0100, 9'h0, 0, 0, 0, 0);
    exec_cmd(C_CALL, 16'h0200, 9'h0, 0, 0, 0, 0);
    exec_cmd(C_CALL, 16'h0300, 9'h0, 0, 0, 0, 0);
    exec_cmd(C_CALL, 16'h0400, 9'h0, 0, 0, 0, 0);
    chk("ovf_count4", stack_count, 4);
    exec_cmd(C_CALL, 16'h0500, 9'h0, 0, 0, 0, 0);
    chk("ovf_err", stack_err, 1);
    chk("ovf_halted", halted, 1);
    chk("ovf_pc_held", pc, 16'h0400);
    chk("ovf_count", stack_count, 4);
    repeat (2) @(negedge clk);
    #1;
    chk("ovf_pc_still_held", pc, 16'h0400);
    start_run();
    chk("ovf_err_sticky", stack_err, 1);
    exec_cmd(C_RET, 16'h0, 9'h0, 0, 0, 0, 0);
    chk("ovf_ret_pc", pc, 16'h0301);
    chk("ovf_ret_count", stack_count, 3);
    chk("ovf_ret_err_sticky", stack_err, 1);

    // Underflow right after reset
    do_reset();
    start_run();
    exec_cmd(C_RET, 16'h0, 9'h0, 0, 0, 0, 0);
    chk("unf_err", stack_err, 1);
    chk("unf_halted", halted, 1);
    chk("unf_pc", pc, 16'h0000);

    // Illegal command
    do_reset();
    start_run();
    exec_cmd(3'd6, 16'h1234, 9'h0, 0, 1, 1, 1);
    chk("ill_err", stack_err, 1);
    chk("ill_halted", halted, 1);
    chk("ill_pc", pc, 16'h0000);

    // Reset while a fetch request is outstanding
    do_reset();
    start_run();
    exec_cmd(C_CALL, 16'h0055, 9'h0, 0, 0, 0, 0);
    chk("midfetch_req", fetch_req, 1);
    chk("midfetch_count", stack_count, 1);
    do_reset();
    #1;
    chk("post_rst_idle_req", fetch_req, 0);
    chk("post_rst_pc", pc, 16'h0000);

    // Randomized command stream
    do_reset();
    start_run();
    for (int k = 0; k < 400; k++) begin
      int r;
      logic [2:0] c;
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
        start_run();
      end
      if (m_halt) start_run();
      r = $urandom_range(0, 31);
      c = (r < 6)  ? C_NEXT :
          (r < 11) ? C_JUMP :
          (r < 17) ? C_BRANCH :
          (r < 23) ? C_CALL :
          (r < 29) ? C_RET :
          (r == 29) ? C_HALT :
          (r == 30) ? 3'd6 : 3'd7;
      exec_cmd(c, 16'($urandom), 9'($urandom), 1'($urandom),
               $urandom_range(0, 2), $urandom_range(0, 2), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
